// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared types and helpers for the FIFO drain path.
//   - unpack_state_t : FSM state encoding for fifo_byte_unpacker
//   - BYTE_W         : width of one output byte
//   - unpack_bytes() : number of bytes carried by one FIFO word
package fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } unpack_state_t;

  function automatic int unpack_bytes(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync
//   Single-clock FIFO with a registered read port (1-cycle read latency).
//   FIFO_DEPTH must be a power of two.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     cs                  chip select; gates both reads and writes
//     wr_en, data_in      write strobe and word
//     rd_en, data_out     read strobe; data_out is valid the cycle after rd_en
//     empty, full         occupancy flags
module fifo_sync #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_out_reg;
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  do_write;
  logic                  do_read;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_write = cs && wr_en && !full;
  assign do_read  = cs && rd_en && !empty;
  assign data_out = data_out_reg;

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_in;
    end
    if (do_read) begin
      data_out_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_read) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker
//   Pops DATA_WIDTH-bit words from fifo_sync and emits them LSB byte first
//   on an 8-bit valid/ready stream, counting completed frames.
//   Optional feature macro: FIFO_UNPACK_CHECKSUM_EN appends one XOR
//   checksum byte per word and moves m_last onto it.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     fifo_empty, fifo_data  FIFO empty flag and read data
//     fifo_cs, fifo_rd_en    FIFO chip select and read strobe
//     m_valid, m_data,       byte stream toward the consumer
//     m_ready, m_last
//     words_sent             completed-frame counter, wraps silently
module fifo_byte_unpacker
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [7:0]            m_data,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BYTES = unpack_bytes(DATA_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  generate
    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH < BYTE_W) begin : g_bad_width
      $error("fifo_byte_unpacker: DATA_WIDTH must be a multiple of 8 and at least 8");
    end
  endgenerate

  unpack_state_t          state_reg;
  logic [DATA_WIDTH-1:0]  shreg_reg;
  logic [DATA_WIDTH-1:0]  shreg_shifted;
  logic [IDX_W-1:0]       idx_reg;
  logic                   cs_reg;
  logic                   m_valid_reg;
  logic                   m_last_reg;
  logic [7:0]             m_data_reg;
  logic [CNT_WIDTH-1:0]   words_sent_reg;
  logic                   handshake;
`ifdef FIFO_UNPACK_CHECKSUM_EN
  logic [7:0]             csum_reg;
`endif

  assign fifo_cs       = cs_reg;
  assign m_valid       = m_valid_reg;
  assign m_last        = m_last_reg;
  assign m_data        = m_data_reg;
  assign words_sent    = words_sent_reg;
  assign handshake     = m_valid_reg && m_ready;
  assign shreg_shifted = shreg_reg >> BYTE_W;

  // The only combinational output: the pop is requested in the same IDLE
  // cycle that sees the FIFO non-empty. cs_reg keeps it low in reset.
  assign fifo_rd_en = cs_reg && (state_reg == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      idx_reg        <= '0;
      cs_reg         <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_last_reg     <= 1'b0;
      m_data_reg     <= '0;
      words_sent_reg <= '0;
`ifdef FIFO_UNPACK_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      cs_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (fifo_rd_en) begin
            state_reg <= WAIT;
          end
        end

        // Read data from the FIFO is valid now, one cycle after the pop.
        WAIT: begin
          shreg_reg   <= fifo_data;
          idx_reg     <= '0;
          m_valid_reg <= 1'b1;
          m_data_reg  <= fifo_data[7:0];
`ifdef FIFO_UNPACK_CHECKSUM_EN
          m_last_reg  <= 1'b0;
          csum_reg    <= '0;
`else
          m_last_reg  <= (BYTES == 1);
`endif
          state_reg   <= SEND;
        end

        // m_data_reg always mirrors shreg_reg[7:0] here, so the byte on the
        // bus holds still until the consumer takes it.
        SEND: begin
          if (handshake) begin
            shreg_reg <= shreg_shifted;
            idx_reg   <= idx_reg + 1'b1;
`ifdef FIFO_UNPACK_CHECKSUM_EN
            csum_reg  <= csum_reg ^ shreg_reg[7:0];
`endif
            if (idx_reg == LAST_IDX) begin
`ifdef FIFO_UNPACK_CHECKSUM_EN
              state_reg  <= CSUM;
              m_data_reg <= csum_reg ^ shreg_reg[7:0];
              m_last_reg <= 1'b1;
`else
              state_reg      <= IDLE;
              m_valid_reg    <= 1'b0;
              m_last_reg     <= 1'b0;
              m_data_reg     <= '0;
              words_sent_reg <= words_sent_reg + 1'b1;
`endif
            end else begin
              m_data_reg <= shreg_shifted[7:0];
`ifdef FIFO_UNPACK_CHECKSUM_EN
              m_last_reg <= 1'b0;
`else
              m_last_reg <= (idx_reg == LAST_IDX - 1'b1);
`endif
            end
          end
        end

`ifdef FIFO_UNPACK_CHECKSUM_EN
        CSUM: begin
          if (handshake) begin
            state_reg      <= IDLE;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            m_data_reg     <= '0;
            words_sent_reg <= words_sent_reg + 1'b1;
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// tb_fifo_byte_unpacker
//   fifo_sync (depth 8, 32-bit) feeding fifo_byte_unpacker, plus a second
//   unpacker with a 2-bit frame counter driven directly for the wrap case.
//   Honours FIFO_UNPACK_CHECKSUM_EN when building expected byte streams.
module tb_fifo_byte_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] din = '0;
  logic        full;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] words_sent;

  logic        fifo_empty2 = 1'b1;
  logic        fifo_cs2;
  logic        fifo_rd_en2;
  logic        m_valid2;
  logic [7:0]  m_data2;
  logic        m_last2;
  logic [1:0]  words_sent2;

  int errors = 0;
  int checks = 0;

  // {m_last, m_data} of every accepted byte, and the expected stream.
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_sync #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (fifo_cs),
    .wr_en    (wr_en),
    .data_in  (din),
    .rd_en    (fifo_rd_en),
    .data_out (fifo_data),
    .empty    (fifo_empty),
    .full     (full)
  );

  fifo_byte_unpacker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .words_sent (words_sent)
  );

  fifo_byte_unpacker #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty2),
    .fifo_data  (32'hA5A5_0F0F),
    .fifo_cs    (fifo_cs2),
    .fifo_rd_en (fifo_rd_en2),
    .m_valid    (m_valid2),
    .m_data     (m_data2),
    .m_ready    (1'b1),
    .m_last     (m_last2),
    .words_sent (words_sent2)
  );

  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back({m_last, m_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_en = 1'b1;
    din   = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // Expected byte stream of one word: LSB first, optional XOR byte.
  function automatic void push_frame(input logic [31:0] w);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b = 8'((w >> (8 * k)) & 32'hFF);
      x = x ^ b;
`ifdef FIFO_UNPACK_CHECKSUM_EN
      exp_q.push_back({1'b0, b});
`else
      exp_q.push_back({(k == 3), b});
`endif
    end
`ifdef FIFO_UNPACK_CHECKSUM_EN
    exp_q.push_back({1'b1, x});
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({fifo_cs, fifo_rd_en, m_valid, m_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got cs/rd/valid/last=%b required 0000",
               {fifo_cs, fifo_rd_en, m_valid, m_last});
    end
    checks++;
    if (m_data !== 8'h00 || words_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got m_data=%h words_sent=%0d required 00/0", m_data, words_sent);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (fifo_cs !== 1'b1) begin
      errors++;
      $display("FAIL reset_cs got fifo_cs=%b required 1", fifo_cs);
    end
    $display("test_reset done");
  endtask

  task automatic test_empty();
    int rd_seen = 0;
    int valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_rd_en === 1'b1) rd_seen++;
      if (m_valid === 1'b1) valid_seen++;
    end
    checks++;
    if (rd_seen != 0 || valid_seen != 0) begin
      errors++;
      $display("FAIL empty_idle got rd_en_cycles=%0d valid_cycles=%0d required 0/0", rd_seen, valid_seen);
    end
    checks++;
    if (words_sent !== 16'd0) begin
      errors++;
      $display("FAIL empty_count got words_sent=%0d required 0", words_sent);
    end
    $display("test_empty done");
  endtask

  task automatic test_single();
    got_q.delete();
    exp_q.delete();
    push_frame(32'h1122_3344);
    m_ready = 1'b1;
    write_word(32'h1122_3344);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL single_rd_en got %b required 1 in first non-empty IDLE cycle", fifo_rd_en);
    end
    tick();
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait got rd_en=%b m_valid=%b required 0/0", fifo_rd_en, m_valid);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h44) begin
      errors++;
      $display("FAIL single_first got m_valid=%b m_data=%h required 1/44", m_valid, m_data);
    end
    for (int n = 0; n < 30 && words_sent != 16'd1; n++) tick();
    checks++;
    if (words_sent !== 16'd1) begin
      errors++;
      $display("FAIL single_count got words_sent=%0d required 1", words_sent);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_len got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_byte[%0d] got last/data=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_single done: %0d bytes", got_q.size());
  endtask

  task automatic test_backpressure();
    got_q.delete();
    exp_q.delete();
    push_frame(32'h1122_3344);
    m_ready = 1'b1;
    write_word(32'h1122_3344);
    tick();
    tick();
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h33 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h last=%b required 1/33/0", i, m_valid, m_data, m_last);
      end
    end
    m_ready = 1'b1;
    for (int n = 0; n < 30 && words_sent != 16'd2; n++) tick();
    checks++;
    if (words_sent !== 16'd2) begin
      errors++;
      $display("FAIL bp_count got words_sent=%0d required 2", words_sent);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_len got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_byte[%0d] got last/data=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_backpressure done: %0d bytes", got_q.size());
  endtask

  task automatic test_full_drain();
    do_reset();
    got_q.delete();
    exp_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_frame(32'(1) << i);
      write_word(32'(1) << i);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 200 && words_sent != 16'd8; n++) tick();
    checks++;
    if (words_sent !== 16'd8) begin
      errors++;
      $display("FAIL drain_count got words_sent=%0d required 8", words_sent);
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got fifo_empty=%b required 1", fifo_empty);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drain_len got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL drain_byte[%0d] got last/data=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_full_drain done: %0d bytes", got_q.size());
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    m_ready = 1'b1;
    write_word(32'hAABB_CCDD);
    for (int n = 0; n < 20 && got_q.size() < 2; n++) tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL mid_bytes got %0d bytes before reset required 2", got_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_cs, fifo_rd_en, m_valid, m_last} !== 4'b0000 || m_data !== 8'h00 || words_sent !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got cs/rd/valid/last=%b data=%h words=%0d required 0000/00/0",
               {fifo_cs, fifo_rd_en, m_valid, m_last}, m_data, words_sent);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    push_frame(32'h0102_0304);
    write_word(32'h0102_0304);
    for (int n = 0; n < 30 && words_sent != 16'd1; n++) tick();
    checks++;
    if (words_sent !== 16'd1) begin
      errors++;
      $display("FAIL mid_count got words_sent=%0d required 1", words_sent);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_len got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_byte[%0d] got last/data=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("test_reset_mid done: first byte %h", (got_q.size() > 0) ? got_q[0][7:0] : 8'h00);
  endtask

  task automatic test_wrap();
    logic [1:0] wrap_exp [5];
    logic [1:0] prev;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    checks++;
    if (words_sent2 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_start got words_sent=%0d required 0", words_sent2);
    end
    fifo_empty2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      prev = words_sent2;
      for (int n = 0; n < 20 && words_sent2 == prev; n++) tick();
      checks++;
      if (words_sent2 !== wrap_exp[k]) begin
        errors++;
        $display("FAIL wrap[%0d] got words_sent=%0d required %0d", k, words_sent2, wrap_exp[k]);
      end
      $display("test_wrap frame %0d words_sent=%0d", k + 1, words_sent2);
    end
    fifo_empty2 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_backpressure();
    test_full_drain();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
